// File: rtl/alu_op_sequencer.sv
// Command-to-ALU sequencer: buffers ALU commands in a FIFO, drives each onto the ALU for one cycle, returns the result.
// Optional result flags (rsp_zero/rsp_neg) are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_op_sequencer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_opcode,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_opcode,
   output logic              alu_enable,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [2:0]        rsp_opcode,
`ifdef ALU_SEQ_FLAGS_EN
   output logic              rsp_zero,
   output logic              rsp_neg,
`endif
   output logic              busy,
   output logic [15:0]       op_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef struct packed {
      logic [2:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   cmd_t              fifo_mem [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              full, empty, push, pop;
   cmd_t              head;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]        alu_opcode_q, alu_opcode_d;
   logic              alu_enable_q, alu_enable_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic [2:0]        rsp_opcode_q, rsp_opcode_d;
   logic [15:0]       op_count_q, op_count_d;
`ifdef ALU_SEQ_FLAGS_EN
   logic              rsp_zero_q, rsp_zero_d, rsp_neg_q, rsp_neg_d;
`endif

   // Extra MSB on each pointer distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = cmd_valid && !full;
   assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

   assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b};
      end
   end

   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_opcode_d = alu_opcode_q;
      alu_enable_d = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_opcode_d = rsp_opcode_q;
      op_count_d   = op_count_q;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero_d   = rsp_zero_q;
      rsp_neg_d    = rsp_neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop          = 1'b1;
               alu_a_d      = head.a;
               alu_b_d      = head.b;
               alu_opcode_d = head.op;
               alu_enable_d = 1'b1;
               state_d      = DRIVE;
            end
         end
         DRIVE: begin
            rsp_result_d = alu_result;
            rsp_opcode_d = alu_opcode_q;
            rsp_valid_d  = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            rsp_zero_d   = (alu_result == '0);
            rsp_neg_d    = alu_result[DATA_W-1];
`endif
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + 16'd1;
               // Launch the next queued command straight away to keep two-cycle throughput.
               if (!empty) begin
                  pop          = 1'b1;
                  alu_a_d      = head.a;
                  alu_b_d      = head.b;
                  alu_opcode_d = head.op;
                  alu_enable_d = 1'b1;
                  state_d      = DRIVE;
               end else begin
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_opcode_q <= '0;
         alu_enable_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_opcode_q <= '0;
         op_count_q   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
         rsp_zero_q   <= 1'b0;
         rsp_neg_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_opcode_q <= alu_opcode_d;
         alu_enable_q <= alu_enable_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_opcode_q <= rsp_opcode_d;
         op_count_q   <= op_count_d;
`ifdef ALU_SEQ_FLAGS_EN
         rsp_zero_q   <= rsp_zero_d;
         rsp_neg_q    <= rsp_neg_d;
`endif
      end
   end

   assign cmd_ready  = !full;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_enable = alu_enable_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_opcode = rsp_opcode_q;
   assign op_count   = op_count_q;
   assign busy       = (state_q != IDLE) || !empty;
`ifdef ALU_SEQ_FLAGS_EN
   assign rsp_zero   = rsp_zero_q;
   assign rsp_neg    = rsp_neg_q;
`endif

endmodule
